// File: rtl/apb_master_ctrl.sv
// APB4 requester: turns single command/response transactions into APB transfers
// across NUM_SLV slaves, with address decode, error capture and wait-state timeout.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_W-1:0]           cmd_addr,
  input  logic [DATA_W-1:0]           cmd_wdata,
  input  logic [DATA_W/8-1:0]         cmd_strb,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_err,
  output logic                        rsp_timeout,
  output logic [NUM_SLV-1:0]          PSEL,
  output logic                        PENABLE,
  output logic [ADDR_W-1:0]           PADDR,
  output logic                        PWRITE,
  output logic [DATA_W-1:0]           PWDATA,
  output logic [DATA_W/8-1:0]         PSTRB,
  input  logic [NUM_SLV*DATA_W-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]          PREADY,
  input  logic [NUM_SLV-1:0]          PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 0;
  localparam int IDX_W  = (SEL_W > 0) ? SEL_W : 1;
  localparam int IDXP_W = IDX_W + 1;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDXP_W-1:0] NSLV_L = IDXP_W'(NUM_SLV);
  localparam logic [CNT_W-1:0]  TMO_L  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx, w_idx_sel;
  logic                w_dec_ok, w_accept;
  logic [NUM_SLV-1:0]  w_onehot;
  logic                w_sel_ready, w_sel_err;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_rsp_err, w_rsp_tmo;
  logic [DATA_W-1:0]   w_rsp_rdata;

  logic                r_cmd_ready, r_rsp_valid, r_rsp_err, r_rsp_tmo, r_penable, r_pwrite;
  logic [DATA_W-1:0]   r_rsp_rdata, r_pwdata;
  logic [NUM_SLV-1:0]  r_psel;
  logic [ADDR_W-1:0]   r_paddr;
  logic [STRB_W-1:0]   r_pstrb;

  // With a single slave there are no select bits; everything maps to slave 0.
  generate
    if (SEL_W > 0) begin : g_idx
      assign w_idx = cmd_addr[ADDR_W-1 -: SEL_W];
    end else begin : g_idx1
      assign w_idx = '0;
    end
  endgenerate

  assign w_dec_ok  = ({1'b0, w_idx} < NSLV_L);
  assign w_idx_sel = w_accept ? w_idx : r_idx;

  always_comb begin
    w_onehot    = '0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      w_onehot[i] = (w_idx_sel == IDX_W'(i));
      if (r_idx == IDX_W'(i)) begin
        w_sel_ready = PREADY[i];
        w_sel_err   = PSLVERR[i];
        w_sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_accept    = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_tmo   = 1'b0;
    w_rsp_rdata = '0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept = w_dec_ok;
          if (w_dec_ok) begin
            w_state_nxt = S_SETUP;
          end else begin
            w_state_nxt = S_RESP;
            w_rsp_err   = 1'b1;
          end
        end
      end
      S_SETUP: w_state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (w_sel_ready) begin
          w_state_nxt = S_RESP;
          w_rsp_err   = w_sel_err;
          if (!r_pwrite && !w_sel_err) w_rsp_rdata = w_sel_rdata;
        end else begin
          // A ready on the final allowed cycle takes the branch above, so it wins.
          w_cnt_nxt = r_cnt + 1'b1;
          if ((TIMEOUT != 0) && (w_cnt_nxt == TMO_L)) begin
            w_state_nxt = S_RESP;
            w_rsp_err   = 1'b1;
            w_rsp_tmo   = 1'b1;
          end
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_rsp_rdata <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_idx       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_rsp_err   <= (w_state_nxt == S_RESP) && w_rsp_err;
      r_rsp_tmo   <= (w_state_nxt == S_RESP) && w_rsp_tmo;
      r_rsp_rdata <= (w_state_nxt == S_RESP) ? w_rsp_rdata : '0;
      r_psel      <= ((w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS)) ? w_onehot : '0;
      r_penable   <= (w_state_nxt == S_ACCESS);
      // Transfer attributes change only on a decoded accept and hold otherwise.
      if (w_accept) begin
        r_idx    <= w_idx;
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
        r_pstrb  <= cmd_write ? cmd_strb : '0;
      end
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_tmo;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PADDR       = r_paddr;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: transaction-timeline model checked every cycle,
// plus literal expectations per scenario and a 3-slave instance for decode errors.
module tb_apb_master_ctrl;

  localparam int TMO = 16;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  logic         PRESET;
  logic         cmd_valid, cmd_ready, cmd_write;
  logic [7:0]   cmd_addr;
  logic [31:0]  cmd_wdata;
  logic [3:0]   cmd_strb;
  logic         rsp_valid, rsp_err, rsp_timeout;
  logic [31:0]  rsp_rdata;
  logic [3:0]   PSEL;
  logic         PENABLE, PWRITE;
  logic [7:0]   PADDR;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [127:0] PRDATA;
  logic [3:0]   PREADY, PSLVERR;

  logic         c3_cmd_valid, c3_cmd_ready, c3_cmd_write;
  logic [7:0]   c3_cmd_addr;
  logic [31:0]  c3_cmd_wdata;
  logic [3:0]   c3_cmd_strb;
  logic         c3_rsp_valid, c3_rsp_err, c3_rsp_timeout;
  logic [31:0]  c3_rsp_rdata;
  logic [2:0]   c3_psel;
  logic         c3_penable, c3_pwrite;
  logic [7:0]   c3_paddr;
  logic [31:0]  c3_pwdata;
  logic [3:0]   c3_pstrb;
  logic [95:0]  c3_prdata;
  logic [2:0]   c3_pready, c3_pslverr;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .NUM_SLV(4), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .NUM_SLV(3), .TIMEOUT(TMO)) dut3 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_write(c3_cmd_write),
    .cmd_addr(c3_cmd_addr), .cmd_wdata(c3_cmd_wdata), .cmd_strb(c3_cmd_strb),
    .rsp_valid(c3_rsp_valid), .rsp_rdata(c3_rsp_rdata), .rsp_err(c3_rsp_err),
    .rsp_timeout(c3_rsp_timeout),
    .PSEL(c3_psel), .PENABLE(c3_penable), .PADDR(c3_paddr), .PWRITE(c3_pwrite),
    .PWDATA(c3_pwdata), .PSTRB(c3_pstrb), .PRDATA(c3_prdata), .PREADY(c3_pready),
    .PSLVERR(c3_pslverr)
  );

  int total = 0;
  int bad   = 0;

  // Model: expected per-cycle outputs plus the last issued APB attributes.
  logic        chk_on;
  logic        e_ready, e_pen, e_rv, e_err, e_tmo;
  logic [3:0]  e_psel;
  logic [31:0] e_rdata;
  logic [7:0]  m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [3:0]  m_strb;

  int          pen_cnt, psel_cnt, rsp_cnt;
  logic [3:0]  cap_psel, cap_pstrb;
  logic [31:0] cap_pwdata, cap_rdata;
  logic        cap_err, cap_tmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic exp_idle();
    e_ready = 1'b1; e_psel = 4'b0; e_pen = 1'b0;
    e_rv = 1'b0; e_err = 1'b0; e_tmo = 1'b0; e_rdata = 32'h0;
  endtask

  task automatic set_slv(input int idx, input logic rdy, input logic err, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      PREADY[i]  = (i == idx) ? rdy : 1'b1;
      PSLVERR[i] = (i == idx) ? err : 1'b1;
      PRDATA[i*32 +: 32] = (i == idx) ? d : (32'hC0DE0000 + 32'(i));
    end
  endtask

  task automatic clear_caps();
    pen_cnt = 0; psel_cnt = 0;
    cap_psel = 4'h0; cap_pstrb = 4'hx; cap_pwdata = 32'hx;
    cap_rdata = 32'hx; cap_err = 1'bx; cap_tmo = 1'bx;
  endtask

  task automatic junk_cmd(input logic wr, input logic [7:0] addr);
    cmd_valid = 1'b1; cmd_write = ~wr; cmd_addr = ~addr;
    cmd_wdata = $urandom; cmd_strb = 4'(~$urandom_range(15, 0));
  endtask

  task automatic enter_setup(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                             input logic [3:0] st, input int idx);
    m_addr = addr; m_write = wr; m_wdata = wr ? wd : 32'h0; m_strb = wr ? st : 4'h0;
    e_ready = 1'b0; e_psel = 4'(1 << idx); e_pen = 1'b0; e_rv = 1'b0;
    junk_cmd(wr, addr);
    set_slv(idx, 1'b1, 1'b1, 32'hBAD0BAD0);
  endtask

  // One command: W wait states before ready, or a timeout when W >= TMO.
  task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic serr,
                        input logic [31:0] rd);
    int idx, acc;
    logic tmo_hit, rdy;
    idx = int'(addr[7:6]);
    tmo_hit = (waits >= TMO);
    acc = tmo_hit ? TMO : waits + 1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    tick();
    enter_setup(wr, addr, wd, st, idx);
    tick();
    for (int k = 0; k < acc; k++) begin
      e_pen = 1'b1;
      rdy = !tmo_hit && (k == waits);
      set_slv(idx, rdy, rdy ? serr : 1'b1, rdy ? rd : 32'hDEAD0000 + 32'(k));
      tick();
    end
    e_psel = 4'b0; e_pen = 1'b0; e_rv = 1'b1; e_ready = 1'b0;
    e_err = tmo_hit | serr; e_tmo = tmo_hit;
    e_rdata = (!wr && !serr && !tmo_hit) ? rd : 32'h0;
    set_slv(idx, 1'b1, 1'b1, 32'hFEEDFACE);
    tick();
    cmd_valid = 1'b0;
    exp_idle();
    set_slv(0, 1'b1, 1'b1, 32'h0);
  endtask

  // Command aborted by reset during its first ACCESS cycle.
  task automatic do_cmd_rst(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] st);
    int idx;
    idx = int'(addr[7:6]);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    tick();
    enter_setup(wr, addr, wd, st, idx);
    tick();
    e_pen = 1'b1;
    set_slv(idx, 1'b0, 1'b1, 32'h0);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    cmd_valid = 1'b0;
    m_addr = 8'h0; m_write = 1'b0; m_wdata = 32'h0; m_strb = 4'h0;
    exp_idle();
    set_slv(0, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge PCLK);
      if (chk_on) begin
        check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
        check("PSEL", 32'(PSEL), 32'(e_psel));
        check("PENABLE", 32'(PENABLE), 32'(e_pen));
        check("PADDR", 32'(PADDR), 32'(m_addr));
        check("PWRITE", 32'(PWRITE), 32'(m_write));
        check("PWDATA", PWDATA, m_wdata);
        check("PSTRB", 32'(PSTRB), 32'(m_strb));
        check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e_tmo));
        check("rsp_rdata", rsp_rdata, e_rdata);
        if (PENABLE) begin pen_cnt++; cap_pstrb = PSTRB; end
        if (PSEL != 4'b0) begin psel_cnt++; cap_psel = PSEL; cap_pwdata = PWDATA; end
        if (rsp_valid) begin rsp_cnt++; cap_rdata = rsp_rdata; cap_err = rsp_err; cap_tmo = rsp_timeout; end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    chk_on = 1'b0; PRESET = 1'b1; rsp_cnt = 0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0; cmd_strb = 4'h0;
    m_addr = 8'h0; m_write = 1'b0; m_wdata = 32'h0; m_strb = 4'h0;
    set_slv(0, 1'b1, 1'b1, 32'h0);
    c3_cmd_valid = 1'b0; c3_cmd_write = 1'b0; c3_cmd_addr = 8'h0;
    c3_cmd_wdata = 32'h0; c3_cmd_strb = 4'h0;
    c3_prdata = {3{32'h77777777}}; c3_pready = 3'b111; c3_pslverr = 3'b111;
    exp_idle();
    clear_caps();
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_c3_cmd_ready", 32'(c3_cmd_ready), 32'd1);
    PRESET = 1'b0;
    chk_on = 1'b1;

    clear_caps();
    do_cmd(1'b1, 8'h45, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    check("wr_pen_cycles", 32'(pen_cnt), 32'd1);
    check("wr_psel_cycles", 32'(psel_cnt), 32'd2);
    check("wr_psel", 32'(cap_psel), 32'h2);
    check("wr_pwdata", cap_pwdata, 32'hDEADBEEF);
    check("wr_rsp_err", 32'(cap_err), 32'd0);

    clear_caps();
    do_cmd(1'b0, 8'hC0, 32'h0, 4'hF, 3, 1'b0, 32'h12345678);
    check("rd_pen_cycles", 32'(pen_cnt), 32'd4);
    check("rd_pstrb", 32'(cap_pstrb), 32'd0);
    check("rd_rdata", cap_rdata, 32'h12345678);

    clear_caps();
    do_cmd(1'b0, 8'h84, 32'h0, 4'h0, 1, 1'b1, 32'h55AA55AA);
    check("slverr_err", 32'(cap_err), 32'd1);
    check("slverr_tmo", 32'(cap_tmo), 32'd0);
    check("slverr_rdata", cap_rdata, 32'd0);

    clear_caps();
    do_cmd(1'b0, 8'h10, 32'h0, 4'h0, TMO - 1, 1'b0, 32'hA1B2C3D4);
    check("edge_pen_cycles", 32'(pen_cnt), 32'd16);
    check("edge_err", 32'(cap_err), 32'd0);
    check("edge_rdata", cap_rdata, 32'hA1B2C3D4);

    clear_caps();
    do_cmd(1'b1, 8'h7C, 32'h0BADF00D, 4'h3, 1000, 1'b0, 32'h0);
    check("tmo_pen_cycles", 32'(pen_cnt), 32'd16);
    check("tmo_err", 32'(cap_err), 32'd1);
    check("tmo_flag", 32'(cap_tmo), 32'd1);

    do_cmd(1'b1, 8'h08, 32'h01020304, 4'h5, 2, 1'b0, 32'h0);
    do_cmd(1'b1, 8'hB1, 32'hA0B0C0D0, 4'hA, 0, 1'b1, 32'h0);
    do_cmd(1'b0, 8'h62, 32'h0, 4'h0, 0, 1'b0, 32'h600D600D);

    c3_cmd_valid = 1'b1; c3_cmd_write = 1'b0; c3_cmd_addr = 8'hC0;
    tick();
    c3_cmd_valid = 1'b0;
    check("dec_rsp_valid", 32'(c3_rsp_valid), 32'd1);
    check("dec_rsp_err", 32'(c3_rsp_err), 32'd1);
    check("dec_rsp_tmo", 32'(c3_rsp_timeout), 32'd0);
    check("dec_rdata", c3_rsp_rdata, 32'd0);
    check("dec_psel", 32'(c3_psel), 32'd0);
    check("dec_penable", 32'(c3_penable), 32'd0);
    check("dec_cmd_ready", 32'(c3_cmd_ready), 32'd0);
    check("dec_paddr", 32'(c3_paddr), 32'd0);
    check("dec_pwrite", 32'(c3_pwrite), 32'd0);
    check("dec_pwdata", c3_pwdata, 32'd0);
    check("dec_pstrb", 32'(c3_pstrb), 32'd0);
    tick();
    check("dec_ready_again", 32'(c3_cmd_ready), 32'd1);
    check("dec_rsp_gone", 32'(c3_rsp_valid), 32'd0);

    snap = rsp_cnt;
    do_cmd_rst(1'b1, 8'hE4, 32'hCAFEBABE, 4'hC);
    tick();
    tick();
    check("rst_no_rsp", 32'(rsp_cnt), 32'(snap));
    clear_caps();
    do_cmd(1'b1, 8'hE4, 32'h13579BDF, 4'h9, 0, 1'b0, 32'h0);
    check("post_rst_rsp", 32'(rsp_cnt), 32'(snap + 1));
    check("post_rst_psel", 32'(cap_psel), 32'h8);
    check("post_rst_err", 32'(cap_err), 32'd0);

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised APB4 requester that converts a simple command/response interface into APB transfers on up to NUM_SLV slaves. It supersedes the fixed three-state single-slave master with an address decode to a one-hot PSEL, PSTRB, PSLVERR capture, a wait-state timeout and a registered response. It sits between the system register-access fabric and the peripheral APB segment.

## Interface
Parameters:
- ADDR_W, 8, PADDR width; the top SEL_W bits select the slave.
- DATA_W, 32, data width (8, 16 or 32); STRB_W = DATA_W/8.
- NUM_SLV, 4, number of slaves (1..16); SEL_W = clog2(NUM_SLV), 0 when NUM_SLV = 1.
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  STRB_W  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- rsp_timeout  out  1  error caused by timeout.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PADDR  out  ADDR_W  address.
- PWRITE  out  1  direction.
- PWDATA  out  DATA_W  write data.
- PSTRB  out  STRB_W  strobes; forced to 0 on reads.
- PRDATA  in  NUM_SLV*DATA_W  slave read data, slave i at bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

## Operation
- States: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: cmd_ready = 1. On cmd_valid, latch addr/write/wdata/strb and index idx = cmd_addr[ADDR_W-1 -: SEL_W].
  - If idx < NUM_SLV: go to SETUP.
  - Else (decode error): go to RESP with err = 1. No APB activity.
- SETUP: PSEL[idx] = 1, PENABLE = 0, with PADDR, PWRITE, PWDATA and PSTRB driven. Always go to ACCESS.
- ACCESS: PSEL[idx] = 1, PENABLE = 1. Only PREADY[idx], PSLVERR[idx] and PRDATA slice idx are observed.
  - If PREADY[idx] = 1: capture err = PSLVERR[idx] and rdata (read with no error only, else 0), then go to RESP.
  - Wait counter increments on each ACCESS cycle with PREADY[idx] = 0. When TIMEOUT != 0 and the counter reaches TIMEOUT: go to RESP with err = 1, timeout = 1, rdata = 0.
- RESP: PSEL = 0, PENABLE = 0, rsp_valid = 1 for exactly this cycle with the captured rsp_*. cmd_ready = 0. Next state is IDLE.
- PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP through the last ACCESS cycle and hold their values afterward. PWDATA and PSTRB are 0 for reads.
- The requester has no rsp_ready; the consumer must accept each pulse.

## Timing
- Reset: state IDLE; every output is 0 except cmd_ready, which is 1 in the first cycle after reset. The wait counter is cleared.
- Reset asserted mid-transfer: PSEL and PENABLE are 0 after the next edge, and no rsp_valid is issued for the aborted command.
- Zero-wait transfer: accept at edge 0, SETUP during cycle 1, ACCESS during cycle 2 (PREADY sampled high), rsp_valid during cycle 3, cmd_ready high again in cycle 4.
- Command throughput: one command per 4 + W cycles, where W is the number of wait states.
- Decode error: accept at edge 0, rsp_valid during cycle 1, cmd_ready during cycle 2.
- Timeout: PENABLE is high for exactly TIMEOUT cycles, then RESP.
- PREADY on the same cycle the counter reaches TIMEOUT: PREADY wins and the transfer completes normally.
- PREADY and PSLVERR from non-selected slaves, and any input value in IDLE/SETUP/RESP, are ignored.

## Test plan
- Write addr 0x45 (NUM_SLV = 4, idx = 1), data 0xDEADBEEF, strb 0xF, zero-wait -> PSEL = 0b0010 for 2 cycles, PENABLE in cycle 2 only, PWDATA = 0xDEADBEEF; rsp_valid in cycle 3 with rsp_err = 0.
- Read addr 0xC0 (idx = 3), slave 3 holds PREADY low for 3 cycles and returns 0x12345678 -> PENABLE high for 4 cycles, PSTRB = 0, rsp_rdata = 0x12345678.
- Read with PSLVERR[2] = 1 on the ready cycle -> rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0.
- TIMEOUT = 16, PREADY held low -> PENABLE high for 16 cycles, then rsp_err = 1, rsp_timeout = 1, and PSEL = 0 in the RESP cycle.
- NUM_SLV = 3, addr 0xC0 -> no PSEL asserted; rsp_valid during cycle 1 with rsp_err = 1.
- PRESET asserted during ACCESS -> all APB outputs 0 next cycle, no rsp_valid; a following write completes normally.
